// File: rtl/ex_stage_md_pkg.sv
// Shared definitions for the execute stage: ALU op codes, exception codes,
// multiply/divide FSM states and small op-classification helpers.
package ex_stage_md_pkg;

  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned EXP_W     = 3;
  localparam int unsigned MEM_OP_W  = 3;
  localparam int unsigned CTRL_OP_W = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM
  } alu_op_e;

  // Codes above UNDEF_INSN belong to earlier stages and pass through untouched.
  typedef enum logic [EXP_W-1:0] {
    NO_EXP     = 3'd0,
    OVF        = 3'd1,
    DIVZ       = 3'd2,
    UNDEF_INSN = 3'd3
  } exp_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // NOP encodings are all-zero so a cleared EX register is a bubble.
  localparam logic [MEM_OP_W-1:0]  MEM_NOP  = '0;
  localparam logic [CTRL_OP_W-1:0] CTRL_NOP = '0;

  function automatic logic is_mul_op(input alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_MULH);
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative radix-2 multiply/divide unit (shift-add MUL, restoring DIV).
// Optional feature macro: EX_DIV_EN (divider datapath present when defined).
// Ports: clk, reset (async, active-high); start/abort/ack handshake;
//        op, opa, opb operands; running/done status; result, divz.
module ex_stage_md_md_unit
  import ex_stage_md_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                ack,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   opa,
  input  logic [DATA_W-1:0]   opb,
  output logic                running,
  output logic                done,
  output logic                divz,
  output logic [DATA_W-1:0]   result
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  md_state_e           state;
  alu_op_e             op_r;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi, lo, mag_b, hi_n, lo_n, fixed;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic                sa, sb, divz_r;

  // One iteration step. MUL: {hi,lo} is the product/multiplier shift pair.
  // DIV: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    hi_n = sum[DATA_W:1];
    lo_n = {sum[0], lo[DATA_W-1:1]};
`ifdef EX_DIV_EN
    if (is_div_op(op_r)) begin
      logic [DATA_W:0] shifted;
      shifted = {hi, lo[DATA_W-1]};
      if (shifted >= {1'b0, mag_b}) begin
        hi_n = DATA_W'(shifted - {1'b0, mag_b});
        lo_n = {lo[DATA_W-2:0], 1'b1};
      end else begin
        hi_n = shifted[DATA_W-1:0];
        lo_n = {lo[DATA_W-2:0], 1'b0};
      end
    end
`endif
  end

  // Sign fix applied to the final step's values.
  always_comb begin
    prod = {hi_n, lo_n};
    if (sa ^ sb) prod = -prod;
    fixed = (op_r == ALU_MULH) ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
`ifdef EX_DIV_EN
    if (op_r == ALU_DIV)
      fixed = divz_r ? '1 : ((sa ^ sb) ? -lo_n : lo_n);
    else if (op_r == ALU_REM)
      fixed = sa ? -hi_n : hi_n;
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      op_r   <= ALU_ADD;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      mag_b  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      divz_r <= 1'b0;
      result <= '0;
    end else if (abort) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_r   <= alu_op_e'(op);
            sa     <= opa[DATA_W-1];
            sb     <= opb[DATA_W-1];
            hi     <= '0;
            lo     <= opa[DATA_W-1] ? -opa : opa;
            mag_b  <= opb[DATA_W-1] ? -opb : opb;
            divz_r <= (opb == '0);
            cnt    <= CNT_W'(DATA_W - 1);
            state  <= MD_RUN;
          end
        end
        MD_RUN: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            result <= fixed;
            state  <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (ack) state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign running = (state == MD_RUN);
  assign done    = (state == MD_DONE);
  assign divz    = divz_r & is_div_op(op_r);

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIV, feeding EX/MEM.
// Optional feature macro: EX_DIV_EN (DIV/REM on the MD unit; otherwise they
// raise UNDEF_INSN in one cycle).
// Ports: clk, reset (async, active-high); IntDetect/Stall/Flush control;
//        EXBusy stall request; ID* inputs from ID; EX* registered outputs,
//        EXOut result and EXFwdData forwarding copy.
module ex_stage_md
  import ex_stage_md_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IntDetect,
  input  logic                 Stall,
  input  logic                 Flush,
  output logic                 EXBusy,
  input  logic [ADDR_W-1:0]    IDPC,
  input  logic                 IDEn,
  input  logic [ALU_OP_W-1:0]  IDALUOp,
  input  logic [DATA_W-1:0]    IDALUIn0,
  input  logic [DATA_W-1:0]    IDALUIn1,
  input  logic                 IDBrFlag,
  input  logic [MEM_OP_W-1:0]  IDMemOp,
  input  logic [DATA_W-1:0]    IDMemWrData,
  input  logic [CTRL_OP_W-1:0] IDCtrlOp,
  input  logic [REG_AW-1:0]    IDDstAddr,
  input  logic                 IDGPRWE_,
  input  logic [EXP_W-1:0]     IDExpCode,
  output logic [ADDR_W-1:0]    EXPC,
  output logic                 EXEn,
  output logic                 EXBrFlag,
  output logic [MEM_OP_W-1:0]  EXMemOp,
  output logic [DATA_W-1:0]    EXMemWrData,
  output logic [CTRL_OP_W-1:0] EXCtrlOp,
  output logic [REG_AW-1:0]    EXDstAddr,
  output logic                 EXGPRWE_,
  output logic [EXP_W-1:0]     EXExpCode,
  output logic [DATA_W-1:0]    EXOut,
  output logic [DATA_W-1:0]    EXFwdData
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic                 en;
    logic                 br;
    logic [MEM_OP_W-1:0]  mem_op;
    logic [DATA_W-1:0]    wr_data;
    logic [CTRL_OP_W-1:0] ctrl_op;
    logic [REG_AW-1:0]    dst;
    logic                 gpr_we_n;
    logic [EXP_W-1:0]     exp;
    logic [DATA_W-1:0]    out;
  } ex_t;

  alu_op_e           op;
  ex_t               ex_q, ex_d, nop;
  logic [DATA_W-1:0] alu_res, md_result;
  logic              ovf, is_md, undef, abort, start;
  logic              md_running, md_done, md_divz;

  // Single-cycle ALU with signed ADD/SUB overflow detect.
  always_comb begin
    op      = alu_op_e'(IDALUOp);
    alu_res = '0;
    ovf     = 1'b0;
    case (op)
      ALU_ADD: begin
        alu_res = IDALUIn0 + IDALUIn1;
        ovf = (IDALUIn0[DATA_W-1] == IDALUIn1[DATA_W-1]) &&
              (alu_res[DATA_W-1] != IDALUIn0[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res = IDALUIn0 - IDALUIn1;
        ovf = (IDALUIn0[DATA_W-1] != IDALUIn1[DATA_W-1]) &&
              (alu_res[DATA_W-1] != IDALUIn0[DATA_W-1]);
      end
      ALU_AND:  alu_res = IDALUIn0 & IDALUIn1;
      ALU_OR:   alu_res = IDALUIn0 | IDALUIn1;
      ALU_XOR:  alu_res = IDALUIn0 ^ IDALUIn1;
      ALU_SLT:  alu_res = DATA_W'($signed(IDALUIn0) < $signed(IDALUIn1));
      ALU_SLTU: alu_res = DATA_W'(IDALUIn0 < IDALUIn1);
      ALU_SLL:  alu_res = IDALUIn0 << IDALUIn1[SH_W-1:0];
      ALU_SRL:  alu_res = IDALUIn0 >> IDALUIn1[SH_W-1:0];
      ALU_SRA:  alu_res = DATA_W'($signed(IDALUIn0) >>> IDALUIn1[SH_W-1:0]);
      default:  alu_res = '0;
    endcase
  end

  // MD start: a pending upstream exception or a kill suppresses it.
  always_comb begin
`ifdef EX_DIV_EN
    is_md = is_mul_op(op) | is_div_op(op);
    undef = 1'b0;
`else
    is_md = is_mul_op(op);
    undef = is_div_op(op);
`endif
    abort  = Flush | IntDetect;
    start  = !md_running && !md_done && IDEn && is_md &&
             (IDExpCode == NO_EXP) && !abort;
    EXBusy = start | md_running;
  end

  ex_stage_md_md_unit #(.DATA_W(DATA_W)) u_md (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .ack     (!Stall),
    .op      (IDALUOp),
    .opa     (IDALUIn0),
    .opb     (IDALUIn1),
    .running (md_running),
    .done    (md_done),
    .divz    (md_divz),
    .result  (md_result)
  );

  // EX register next state: kill > stall > MD result > bubble > ALU result.
  always_comb begin
    nop          = '0;
    nop.gpr_we_n = 1'b1;
    ex_d         = ex_q;
    if (abort) begin
      ex_d = nop;
    end else if (!Stall) begin
      ex_d.pc       = IDPC;
      ex_d.en       = IDEn;
      ex_d.br       = IDBrFlag;
      ex_d.mem_op   = IDMemOp;
      ex_d.wr_data  = IDMemWrData;
      ex_d.ctrl_op  = IDCtrlOp;
      ex_d.dst      = IDDstAddr;
      ex_d.gpr_we_n = IDGPRWE_;
      ex_d.exp      = IDExpCode;
      ex_d.out      = alu_res;
      if (md_done) begin
        ex_d.en  = 1'b1;
        ex_d.out = md_result;
        ex_d.exp = md_divz ? DIVZ : NO_EXP;
      end else if (EXBusy) begin
        ex_d = nop;
      end else if (IDEn && (IDExpCode == NO_EXP)) begin
        if (undef) begin
          ex_d.exp      = UNDEF_INSN;
          ex_d.gpr_we_n = 1'b1;
        end else if (ovf) begin
          ex_d.exp = OVF;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q          <= '0;
      ex_q.gpr_we_n <= 1'b1;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign EXPC        = ex_q.pc;
  assign EXEn        = ex_q.en;
  assign EXBrFlag    = ex_q.br;
  assign EXMemOp     = ex_q.mem_op;
  assign EXMemWrData = ex_q.wr_data;
  assign EXCtrlOp    = ex_q.ctrl_op;
  assign EXDstAddr   = ex_q.dst;
  assign EXGPRWE_    = ex_q.gpr_we_n;
  assign EXExpCode   = ex_q.exp;
  assign EXOut       = ex_q.out;
  assign EXFwdData   = ex_q.out;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md with hand-computed expected values.
module tb_ex_stage_md;
  import ex_stage_md_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset, IntDetect, Stall, Flush, EXBusy;
  logic [29:0]          IDPC, EXPC;
  logic                 IDEn, EXEn, IDBrFlag, EXBrFlag, IDGPRWE_, EXGPRWE_;
  logic [ALU_OP_W-1:0]  IDALUOp;
  logic [31:0]          IDALUIn0, IDALUIn1, IDMemWrData, EXMemWrData, EXOut, EXFwdData;
  logic [MEM_OP_W-1:0]  IDMemOp, EXMemOp;
  logic [CTRL_OP_W-1:0] IDCtrlOp, EXCtrlOp;
  logic [4:0]           IDDstAddr, EXDstAddr;
  logic [EXP_W-1:0]     IDExpCode, EXExpCode;

  int n_chk  = 0;
  int n_pass = 0;

  ex_stage_md #(.DATA_W(32), .ADDR_W(30), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .IntDetect(IntDetect), .Stall(Stall), .Flush(Flush),
    .EXBusy(EXBusy), .IDPC(IDPC), .IDEn(IDEn), .IDALUOp(IDALUOp),
    .IDALUIn0(IDALUIn0), .IDALUIn1(IDALUIn1), .IDBrFlag(IDBrFlag), .IDMemOp(IDMemOp),
    .IDMemWrData(IDMemWrData), .IDCtrlOp(IDCtrlOp), .IDDstAddr(IDDstAddr),
    .IDGPRWE_(IDGPRWE_), .IDExpCode(IDExpCode), .EXPC(EXPC), .EXEn(EXEn),
    .EXBrFlag(EXBrFlag), .EXMemOp(EXMemOp), .EXMemWrData(EXMemWrData),
    .EXCtrlOp(EXCtrlOp), .EXDstAddr(EXDstAddr), .EXGPRWE_(EXGPRWE_),
    .EXExpCode(EXExpCode), .EXOut(EXOut), .EXFwdData(EXFwdData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [ALU_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    IDEn = 1'b1; IDALUOp = op; IDALUIn0 = a; IDALUIn1 = b;
    IDGPRWE_ = 1'b0; IDDstAddr = 5'd7; IDPC = 30'h100;
  endtask

  task automatic idle();
    IDEn = 1'b0; IDALUOp = ALU_ADD; IDALUIn0 = '0; IDALUIn1 = '0;
    IDGPRWE_ = 1'b1; IDDstAddr = '0; IDPC = '0;
  endtask

  // Issue an MD op, count busy cycles, then check the captured result.
  task automatic run_md(input string tag, input logic [ALU_OP_W-1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [EXP_W-1:0] ex);
    int busy;
    int en_seen;
    drive(op, a, b);
    #1;
    busy = 0;
    en_seen = 0;
    while (EXBusy && busy < 100) begin
      busy++;
      tick();
      if (EXEn) en_seen++;
    end
    check({tag, "_busy"}, 64'(busy), 64'(33));
    check({tag, "_bubble"}, 64'(en_seen), 64'(0));
    tick();
    check({tag, "_out"}, 64'(EXOut), 64'(res));
    check({tag, "_exp"}, 64'(EXExpCode), 64'(ex));
    check({tag, "_en"}, 64'(EXEn), 64'(1));
    idle();
  endtask

  initial begin
    int en_seen;
    reset = 1'b1; IntDetect = 1'b0; Stall = 1'b0; Flush = 1'b0;
    IDBrFlag = 1'b0; IDMemOp = '0; IDMemWrData = '0; IDCtrlOp = '0; IDExpCode = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_en", 64'(EXEn), 64'(0));
    check("rst_we", 64'(EXGPRWE_), 64'(1));
    check("rst_out", 64'(EXOut), 64'(0));
    check("rst_busy", 64'(EXBusy), 64'(0));
    check("rst_exp", 64'(EXExpCode), 64'(NO_EXP));

    drive(ALU_ADD, 32'h7FFFFFFF, 32'h1);
    tick();
    check("add_ovf_out", 64'(EXOut), 64'h80000000);
    check("add_ovf_exp", 64'(EXExpCode), 64'(OVF));
    check("add_dst", 64'(EXDstAddr), 64'(7));
    check("add_fwd", 64'(EXFwdData), 64'h80000000);

    drive(ALU_SUB, 32'd10, 32'd3);
    tick();
    check("sub_out", 64'(EXOut), 64'(7));
    check("sub_exp", 64'(EXExpCode), 64'(NO_EXP));

    // Upstream exception suppresses the MD start and passes through.
    drive(ALU_MUL, 32'd3, 32'd3);
    IDExpCode = 3'd5;
    #1;
    check("exp_pass_busy", 64'(EXBusy), 64'(0));
    tick();
    check("exp_pass_code", 64'(EXExpCode), 64'(5));
    IDExpCode = '0;
    idle();
    tick();

    run_md("mul_neg", ALU_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, NO_EXP);
    run_md("mulh_neg", ALU_MULH, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, NO_EXP);
    run_md("mul_pos", ALU_MUL, 32'h12345678, 32'h10, 32'h23456780, NO_EXP);
    run_md("mulh_pos", ALU_MULH, 32'h12345678, 32'h10, 32'h00000001, NO_EXP);

`ifdef EX_DIV_EN
    run_md("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, NO_EXP);
    run_md("rem_neg", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, NO_EXP);
    run_md("div_zero", ALU_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, DIVZ);
    run_md("rem_zero", ALU_REM, 32'd5, 32'd0, 32'd5, DIVZ);
    run_md("div_min", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, NO_EXP);
    run_md("div_pos", ALU_DIV, 32'd100, 32'd7, 32'd14, NO_EXP);
    run_md("rem_negdiv", ALU_REM, 32'd7, 32'hFFFFFFFE, 32'd1, NO_EXP);
`else
    drive(ALU_DIV, 32'hFFFFFFF9, 32'd2);
    #1;
    check("div_off_busy", 64'(EXBusy), 64'(0));
    tick();
    check("div_off_exp", 64'(EXExpCode), 64'(UNDEF_INSN));
    check("div_off_we", 64'(EXGPRWE_), 64'(1));
    check("div_off_en", 64'(EXEn), 64'(1));
    idle();
`endif

    // Stall held in DONE: result captured exactly once after release.
    drive(ALU_MUL, 32'd6, 32'd7);
    #1;
    for (int i = 0; i < 100 && EXBusy; i++) tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_out", 64'(EXOut), 64'(0));
      check("stall_no_busy", 64'(EXBusy), 64'(0));
    end
    Stall = 1'b0;
    tick();
    check("stall_rel_out", 64'(EXOut), 64'(42));
    check("stall_rel_en", 64'(EXEn), 64'(1));
    idle();
    tick();
    check("stall_once_en", 64'(EXEn), 64'(0));

    // Flush mid-RUN aborts with no late write.
    drive(ALU_MUL, 32'd5, 32'd9);
    #1;
    repeat (10) tick();
    Flush = 1'b1;
    idle();
    tick();
    Flush = 1'b0;
    #1;
    check("flush_busy", 64'(EXBusy), 64'(0));
    check("flush_en", 64'(EXEn), 64'(0));
    check("flush_out", 64'(EXOut), 64'(0));
    en_seen = 0;
    repeat (40) begin
      tick();
      if (EXEn) en_seen++;
    end
    check("flush_no_write", 64'(en_seen), 64'(0));
    drive(ALU_ADD, 32'd2, 32'd3);
    tick();
    check("post_flush_add", 64'(EXOut), 64'(5));
    check("post_flush_en", 64'(EXEn), 64'(1));

    // Interrupt loads a NOP over a valid ALU op.
    drive(ALU_ADD, 32'd4, 32'd4);
    IntDetect = 1'b1;
    tick();
    IntDetect = 1'b0;
    check("int_en", 64'(EXEn), 64'(0));
    check("int_out", 64'(EXOut), 64'(0));

    // Stall on a single-cycle op holds the register.
    drive(ALU_ADD, 32'd1, 32'd1);
    Stall = 1'b1;
    tick();
    check("stall_alu_hold", 64'(EXOut), 64'(0));
    Stall = 1'b0;
    tick();
    check("stall_alu_rel", 64'(EXOut), 64'(2));
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
